// File: rtl/cascade_count_sched.sv
// Round-robin scheduler for a shared cascaded counter chain: grants one requester,
// runs the chain to its terminal counts, then holds a done handshake. Optional `CASCADE_PAUSE_EN adds a pause input.
module cascade_count_sched #(
    parameter int STG_W = 4,
    parameter int N_STG = 3,
    parameter int N_REQ = 2,
    parameter int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*N_STG*STG_W-1:0] req_tc,
    output logic [N_REQ-1:0]             req_ready,
    input  logic                         abort,
    input  logic                         done_ack,
`ifdef CASCADE_PAUSE_EN
    input  logic                         pause,
`endif
    output logic                         busy,
    output logic [GID_W-1:0]             grant_id,
    output logic [N_STG*STG_W-1:0]       stage_cnt,
    output logic [N_STG-1:0]             stage_tick,
    output logic                         done_valid,
    output logic                         done_abort
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state_reg;
    logic [GID_W-1:0] rr_reg;
    logic [GID_W-1:0] grant_reg;
    logic             done_abort_reg;
    logic [STG_W-1:0] cnt_reg [N_STG];
    logic [STG_W-1:0] tc_reg  [N_STG];

    logic             win_found;
    logic [GID_W-1:0] win_id;
    logic             accept;
    logic             pause_int;
    logic             step_en;
    logic             all_tc;
    logic [N_STG-1:0] at_tc;
    logic [N_STG-1:0] adv;

`ifdef CASCADE_PAUSE_EN
    assign pause_int = pause;
`else
    assign pause_int = 1'b0;
`endif

    // First requesting index at or after the round-robin pointer, with wrap.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_reg) + i) % N_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = GID_W'(idx);
            end
        end
    end

    assign accept  = (state_reg == IDLE) && win_found && !rst;
    // Abort beats pause; both freeze the chain and suppress ticks.
    assign step_en = (state_reg == COUNT) && !abort && !pause_int;
    assign all_tc  = &at_tc;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = accept && (win_id == GID_W'(gi));
    end

    for (genvar gi = 0; gi < N_STG; gi++) begin : g_stage
        assign at_tc[gi] = (cnt_reg[gi] == tc_reg[gi]);
        if (gi == 0) begin : g_first
            assign adv[gi] = 1'b1;
        end else begin : g_upper
            assign adv[gi] = &at_tc[gi-1:0];
        end
        assign stage_tick[gi]                  = step_en && adv[gi] && at_tc[gi];
        assign stage_cnt[gi*STG_W +: STG_W]    = cnt_reg[gi];
    end

    // Counter chain; the final cycle keeps the terminal values visible for done reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_STG; i++) begin
                cnt_reg[i] <= '0;
                tc_reg[i]  <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N_STG; i++) begin
                cnt_reg[i] <= '0;
                tc_reg[i]  <= req_tc[(int'(win_id)*N_STG + i)*STG_W +: STG_W];
            end
        end else if (step_en && !all_tc) begin
            for (int i = 0; i < N_STG; i++) begin
                if (adv[i]) begin
                    cnt_reg[i] <= at_tc[i] ? '0 : cnt_reg[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            rr_reg         <= '0;
            grant_reg      <= '0;
            done_abort_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        grant_reg      <= win_id;
                        rr_reg         <= (win_id == GID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
                        done_abort_reg <= 1'b0;
                        state_reg      <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        done_abort_reg <= 1'b1;
                        state_reg      <= DONE;
                    end else if (!pause_int && all_tc) begin
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        done_abort_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done_valid = (state_reg == DONE);
    assign done_abort = done_abort_reg;
    assign grant_id   = grant_reg;

endmodule
